// File: rtl/serial_sub_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial subtractor.
// One full-subtractor cell is reused LSB-first, so a WIDTH-bit result takes WIDTH cycles.
module serial_sub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;

  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_bin, r_id, r_last;
  logic             r_gnt0, r_gnt1, r_done, r_done_id, r_borrow, r_zero;
  logic [WIDTH-1:0] r_diff;

  logic             w_req, w_sel1, w_last_bit;
  logic             w_ab, w_d, w_bout;
  logic [WIDTH-1:0] w_res_nxt;

  // r_last holds the id granted most recently; on a tie the other side wins.
  assign w_req      = req0 | req1;
  assign w_sel1     = req1 & (~req0 | ~r_last);
  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  assign w_ab      = r_a[0] ^ r_b[0];
  assign w_d       = w_ab ^ r_bin;
  assign w_bout    = (~r_a[0] & r_b[0]) | (~w_ab & r_bin);
  // The last cell output lands in the MSB; the stored partial result fills the rest.
  assign w_res_nxt = {w_d, r_res};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req)      w_next = S_RUN;
      S_RUN:   if (w_last_bit) w_next = S_DONE;
      S_DONE:                  w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_bin     <= 1'b0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_diff    <= '0;
      r_borrow  <= 1'b0;
      r_zero    <= 1'b1;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_req) begin
          r_a    <= w_sel1 ? a1 : a0;
          r_b    <= w_sel1 ? b1 : b0;
          r_bin  <= 1'b0;
          r_cnt  <= '0;
          r_id   <= w_sel1;
          r_last <= w_sel1;
          r_gnt0 <= ~w_sel1;
          r_gnt1 <= w_sel1;
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_nxt[WIDTH-1:1];
          r_bin <= w_bout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last_bit) begin
            r_diff    <= w_res_nxt;
            r_borrow  <= w_bout;
            r_zero    <= (w_res_nxt == '0);
            r_done_id <= r_id;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign done_id = r_done_id;
  assign diff    = r_diff;
  assign borrow  = r_borrow;
  assign zero    = r_zero;
endmodule

// File: tb/tb_serial_sub_arbiter.sv
// Scoreboard bench: expected results are queued at grant time and checked at done.
module tb_serial_sub_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, done_id, borrow, zero;
  logic [W-1:0] diff;

  serial_sub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .diff(diff), .borrow(borrow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0, n_err = 0;
  int           cyc = 0, gnt_cyc = 0;
  logic [W-1:0] ea0 = '0, eb0 = '0, ea1 = '0, eb1 = '0;
  logic [W-1:0] h_diff = '0;
  logic         h_borrow = 1'b0, h_zero = 1'b1, h_id = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id     = id;
    e.diff   = a - b;
    e.borrow = (a < b);
    e.zero   = ((a - b) == '0);
    return e;
  endfunction

  task automatic hold_reset();
    h_diff = '0; h_borrow = 1'b0; h_zero = 1'b1; h_id = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: queue on grant, compare on done, check outputs hold in between.
  always @(negedge clk) begin
    if (rst) hold_reset();
    else begin
      chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      if (gnt0 | gnt1) begin
        sb.push_back(gnt1 ? model(1'b1, ea1, eb1) : model(1'b0, ea0, eb0));
        gnt_cyc = cyc;
      end
      if (done) begin
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_lat", cyc - gnt_cyc, W);
        if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_diff",   {24'd0, diff},    {24'd0, e.diff});
          chk("sb_borrow", {31'd0, borrow},  {31'd0, e.borrow});
          chk("sb_zero",   {31'd0, zero},    {31'd0, e.zero});
          chk("sb_id",     {31'd0, done_id}, {31'd0, e.id});
          h_diff = e.diff; h_borrow = e.borrow; h_zero = e.zero; h_id = e.id;
        end
      end else begin
        chk("hold", {21'd0, diff, borrow, zero, done_id}, {21'd0, h_diff, h_borrow, h_zero, h_id});
      end
    end
  end

  task automatic wait_gnt(input logic id, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) begin n = i; break; end
    end
    if (n == 0) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (seen == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input bit tgl);
    int n;
    @(negedge clk);
    if (id) begin ea1 = a; eb1 = b; a1 = a; b1 = b; req1 = 1'b1; end
    else    begin ea0 = a; eb0 = b; a0 = a; b0 = b; req0 = 1'b1; end
    wait_gnt(id, n);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("gnt_pulse", {31'd0, gnt0 | gnt1}, 32'd0);
    if (tgl)
      for (int i = 0; i < W - 3; i++) begin
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        @(negedge clk);
      end
    wait_done();
  endtask

  initial begin
    int n, c0, c1, c2;
    #2 rst = 1'b1;
    #1;
    chk("rst_out", {21'd0, gnt0, gnt1, busy, done, done_id, borrow, zero},
                   {21'd0, 7'b0000001});
    chk("rst_diff", {24'd0, diff}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_op(1'b0, 8'h5A, 8'h3C, 1'b0);
    chk("t27_diff", {24'd0, diff}, 32'h1E);
    chk("t27_flags", {29'd0, borrow, zero, done_id}, 32'd0);

    do_op(1'b1, 8'h10, 8'h20, 1'b0);
    chk("t28_diff", {24'd0, diff}, 32'hF0);
    chk("t28_flags", {29'd0, borrow, zero, done_id}, 32'b101);

    do_op(1'b0, 8'h77, 8'h77, 1'b0);
    chk("t30_eq", {23'd0, diff, zero, borrow}, {23'd0, 8'h00, 1'b1, 1'b0});
    do_op(1'b1, 8'h00, 8'hFF, 1'b0);
    chk("t30_uf", {24'd0, diff[7:0]} | {23'd0, borrow, 8'd0}, {23'd0, 1'b1, 8'h01});

    // Abort in the middle of RUN; no done may follow.
    @(negedge clk);
    ea0 = 8'h9C; eb0 = 8'h21; a0 = 8'h9C; b0 = 8'h21; req0 = 1'b1;
    wait_gnt(1'b0, n);
    req0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out", {28'd0, busy, done, zero, borrow}, 32'b0010);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    sb.delete();
    hold_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    do_op(1'b1, 8'hC3, 8'h3C, 1'b0);
    chk("post_abort", {24'd0, diff}, 32'h87);

    do_op(1'b0, 8'hA5, 8'h5B, 1'b1);
    do_op(1'b1, 8'h3E, 8'hE3, 1'b1);
    for (int k = 0; k < 4; k++)
      do_op(1'(k), W'($urandom), W'($urandom), 1'b1);

    // Both held from reset: 0 wins first, then strict alternation.
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    hold_reset();
    ea0 = 8'h33; eb0 = 8'h11; a0 = 8'h33; b0 = 8'h11;
    ea1 = 8'h01; eb1 = 8'h02; a1 = 8'h01; b1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_gnt(1'b0, n);
    c0 = cyc;
    chk("rr_first", n, 32'd1);
    wait_gnt(1'b1, n);
    c1 = cyc;
    chk("rr_gap1", c1 - c0, W + 2);
    wait_gnt(1'b0, n);
    c2 = cyc;
    chk("rr_gap2", c2 - c1, W + 2);
    req0 = 1'b0; req1 = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_sub_arbiter.md
SERIAL_SUB_ARBITER -- requirements
Module: serial_sub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req0  input  1  requester 0 subtract request; held until gnt0.
REQ-005 SHALL have port a0, b0  input  WIDTH each  requester 0 minuend and subtrahend.
REQ-006 SHALL have port req1  input  1  requester 1 subtract request; held until gnt1.
REQ-007 SHALL have port a1, b1  input  WIDTH each  requester 1 minuend and subtrahend.
REQ-008 SHALL have port gnt0, gnt1  output  1 each  registered one-cycle grant pulses.
REQ-009 SHALL have port busy  output  1  high while an operation is held or in progress (state RUN or DONE).
REQ-010 SHALL have port done  output  1  registered one-cycle pulse; result valid.
REQ-011 SHALL have port done_id  output  1  requester that owns the current result (0/1).
REQ-012 SHALL have port diff  output  WIDTH  result a-b, modulo 2^WIDTH.
REQ-013 SHALL have port borrow  output  1  final borrow; 1 iff a<b unsigned.
REQ-014 SHALL have port zero  output  1  1 iff diff==0.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 SHALL, at an edge in IDLE with req0 or req1 high, latch the selected requester's a/b, clear the internal borrow, set the bit counter to 0, enter RUN, and drive the matching gnt high for exactly the following cycle.
REQ-017 SHALL, with only one request high, grant that requester; with both high, grant the one not granted last (round-robin); the last-grant pointer SHALL reset to 1 so requester 0 wins first.
REQ-018 SHALL, in RUN, process one bit per edge LSB-first through a single full-subtractor cell: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin); d shifted into the result register from the MSB, operands shifted right, bin <= bout.
REQ-019 SHALL, on the edge that processes bit WIDTH-1, enter DONE and update diff, borrow, zero and done_id together; done SHALL be high for the single following cycle.
REQ-020 SHALL, at the next edge in DONE, return to IDLE; requests are not sampled in RUN or DONE.
REQ-021 SHALL give latency: gnt high in the cycle after acceptance edge E0; done high in the cycle after edge E0+WIDTH (WIDTH cycles after gnt); minimum acceptance spacing WIDTH+2 cycles.
REQ-022 SHALL hold diff, borrow, zero and done_id stable from done until the next done.
REQ-023 SHALL ignore changes on req/a/b of either requester after acceptance until IDLE; a held non-granted request SHALL be served at the next IDLE sample.
REQ-024 SHALL never assert gnt0 and gnt1 in the same cycle, nor assert done outside DONE.

Reset
REQ-025 SHALL, while rst is high, asynchronously force state IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, diff=0, borrow=0, zero=1, counter=0, internal borrow=0, last-grant pointer=1.
REQ-026 SHALL, on reset during RUN or DONE, abort the operation with no done pulse; the interrupted request SHALL be re-served only if still held after rst deasserts.

Verification (WIDTH=8)
REQ-027 SHALL cover: req0, a0=0x5A, b0=0x3C -> gnt0 one cycle, done 8 cycles later, diff=0x1E, borrow=0, zero=0, done_id=0.
REQ-028 SHALL cover: req1, a1=0x10, b1=0x20 -> diff=0xF0, borrow=1, zero=0, done_id=1.
REQ-029 SHALL cover: req0 and req1 both held from reset -> gnt0 first, then gnt1 exactly WIDTH+2 cycles later, then gnt0 again if both still held.
REQ-030 SHALL cover: a=0x77, b=0x77 -> diff=0x00, zero=1, borrow=0; and a=0x00, b=0xFF -> diff=0x01, borrow=1.
REQ-031 SHALL cover: rst pulsed after 4 RUN edges -> busy=0, no done, diff=0, zero=1 immediately; next request then completes with a correct result.
REQ-032 SHALL cover: operand inputs toggled randomly during RUN -> result still equals the values latched at grant.
